// File: rtl/tmr_fault_manager.sv
// TMR fault manager: counts single-ALU dissent, retries no-majority results and
// escalates to a sticky fatal state once the retry budget is exhausted.
//
//   state   | meaning
//   MONITOR | normal operation, watching each valid result
//   RETRY   | re-evaluating a no-majority result with the pipeline held
//   FATAL   | unrecoverable fault, pipeline held until reset
module tmr_fault_manager #(
    parameter int CNT_W      = 8,
    parameter int ERR_THRESH = 16,
    parameter int MAX_RETRY  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             alu1_alu2_match,
    input  logic             alu1_alu3_match,
    input  logic             alu2_alu3_match,
    input  logic [1:0]       majority_status,
    input  logic             clear_counts,
    output logic             stall_E,
    output logic             retry_active,
    output logic             fatal_error,
    output logic [CNT_W-1:0] err_cnt1,
    output logic [CNT_W-1:0] err_cnt2,
    output logic [CNT_W-1:0] err_cnt3,
    output logic [2:0]       degraded,
    output logic             fault_irq,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        ST_MONITOR = 2'b00,
        ST_RETRY   = 2'b01,
        ST_FATAL   = 2'b10
    } state_t;

    localparam int                 RETRY_W          = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT      = RETRY_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0]   CNT_MAX          = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]     THRESH_EXT       = (CNT_W + 1)'(ERR_THRESH);
    // A threshold the counter can never hold must never mark an ALU degraded.
    localparam bit                 THRESH_REACHABLE = (ERR_THRESH > 0) && ((ERR_THRESH >> CNT_W) == 0);

    state_t             state;
    logic [RETRY_W-1:0] retry_cnt;
    logic [CNT_W-1:0]   cnt_q   [3];
    logic [CNT_W-1:0]   cnt_nxt [3];
    logic [1:0]         match_cnt;
    logic               single_fault;
    logic               no_majority;
    logic [2:0]         dissent;
    logic [2:0]         deg_hit;
    logic [2:0]         deg_rise;
    logic               fail_eval;
    logic               fatal_enter;

    assign match_cnt    = {1'b0, alu1_alu2_match} + {1'b0, alu1_alu3_match} + {1'b0, alu2_alu3_match};
    assign single_fault = (majority_status == 2'b01) && (match_cnt == 2'd1);
    assign no_majority  = majority_status[1] || ((majority_status == 2'b01) && (match_cnt != 2'd1));

    // The lone agreeing pair names the two healthy ALUs; the third one dissented.
    assign dissent[0] = single_fault && alu2_alu3_match;
    assign dissent[1] = single_fault && alu1_alu3_match;
    assign dissent[2] = single_fault && alu1_alu2_match;

    assign fail_eval   = ex_valid && no_majority;
    assign fatal_enter = (state == ST_RETRY) && fail_eval && (retry_cnt >= RETRY_LIMIT);

    assign stall_E = (!reset && (state == ST_FATAL)) || fail_eval;

    always_comb begin
        deg_hit = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (ex_valid && dissent[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
                deg_hit[i] = THRESH_REACHABLE && ({1'b0, cnt_nxt[i]} == THRESH_EXT);
            end
            if (clear_counts) begin
                cnt_nxt[i] = '0;
                deg_hit[i] = 1'b0;
            end
        end
    end

    assign deg_rise = deg_hit & ~degraded;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_MONITOR;
            retry_cnt    <= '0;
            retry_active <= 1'b0;
            fatal_error  <= 1'b0;
            fault_irq    <= 1'b0;
            degraded     <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_nxt[i];
            end
            degraded  <= clear_counts ? 3'b000 : (degraded | deg_hit);
            fault_irq <= (|deg_rise) || fatal_enter;

            case (state)
                ST_MONITOR: begin
                    if (fail_eval) begin
                        state        <= ST_RETRY;
                        retry_cnt    <= RETRY_W'(1);
                        retry_active <= 1'b1;
                    end
                end
                ST_RETRY: begin
                    if (!fail_eval) begin
                        state        <= ST_MONITOR;
                        retry_cnt    <= '0;
                        retry_active <= 1'b0;
                    end else if (retry_cnt >= RETRY_LIMIT) begin
                        state        <= ST_FATAL;
                        retry_active <= 1'b0;
                        fatal_error  <= 1'b1;
                    end else begin
                        retry_cnt <= retry_cnt + RETRY_W'(1);
                    end
                end
                ST_FATAL: begin
                    fatal_error <= 1'b1;
                end
                default: begin
                    state        <= ST_MONITOR;
                    retry_cnt    <= '0;
                    retry_active <= 1'b0;
                end
            endcase
        end
    end

    assign err_cnt1  = cnt_q[0];
    assign err_cnt2  = cnt_q[1];
    assign err_cnt3  = cnt_q[2];
    assign fsm_state = state;

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Self-checking bench for tmr_fault_manager: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the fault rules.
module tb_tmr_fault_manager;

    localparam int CNT_W      = 8;
    localparam int ERR_THRESH = 16;
    localparam int MAX_RETRY  = 2;
    localparam int CNT_SAT    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             ex_valid;
    logic             alu1_alu2_match;
    logic             alu1_alu3_match;
    logic             alu2_alu3_match;
    logic [1:0]       majority_status;
    logic             clear_counts;
    logic             stall_E;
    logic             retry_active;
    logic             fatal_error;
    logic [CNT_W-1:0] err_cnt1;
    logic [CNT_W-1:0] err_cnt2;
    logic [CNT_W-1:0] err_cnt3;
    logic [2:0]       degraded;
    logic             fault_irq;
    logic [1:0]       fsm_state;

    always #5 clk = ~clk;

    tmr_fault_manager #(
        .CNT_W      (CNT_W),
        .ERR_THRESH (ERR_THRESH),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ex_valid        (ex_valid),
        .alu1_alu2_match (alu1_alu2_match),
        .alu1_alu3_match (alu1_alu3_match),
        .alu2_alu3_match (alu2_alu3_match),
        .majority_status (majority_status),
        .clear_counts    (clear_counts),
        .stall_E         (stall_E),
        .retry_active    (retry_active),
        .fatal_error     (fatal_error),
        .err_cnt1        (err_cnt1),
        .err_cnt2        (err_cnt2),
        .err_cnt3        (err_cnt3),
        .degraded        (degraded),
        .fault_irq       (fault_irq),
        .fsm_state       (fsm_state)
    );

    int n_chk = 0;
    int n_fail = 0;
    int irq_seen = 0;

    // Model: mode 0 = MONITOR, 1 = RETRY, 2 = FATAL; evals = failed evaluations of the current op.
    int m_mode = 0;
    int m_evals = 0;
    int m_cnt [3] = '{0, 0, 0};
    bit m_deg [3] = '{0, 0, 0};
    bit m_fatal = 0;
    bit m_irq = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit ev, input bit a12, input bit a13, input bit a23,
                        input bit [1:0] st, input bit clr);
        int  nm;
        int  d;
        bit  single;
        bit  nomaj;
        bit  rise;
        bit  to_fatal;
        @(negedge clk);
        reset           = rst;
        ex_valid        = ev;
        alu1_alu2_match = a12;
        alu1_alu3_match = a13;
        alu2_alu3_match = a23;
        majority_status = st;
        clear_counts    = clr;
        nm     = int'(a12) + int'(a13) + int'(a23);
        single = (st == 2'b01) && (nm == 1);
        nomaj  = (st[1] == 1'b1) || ((st == 2'b01) && (nm != 1));
        #1;
        chk("stall_E", 32'(stall_E), 32'((m_mode == 2 && !rst) || (ev && nomaj)));
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_evals = 0; m_fatal = 0; m_irq = 0;
            for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_deg[i] = 0; end
        end else begin
            rise = 0;
            to_fatal = 0;
            if (clr) begin
                for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_deg[i] = 0; end
            end else if (ev && single) begin
                d = a23 ? 0 : (a13 ? 1 : 2);
                if (m_cnt[d] < CNT_SAT) begin
                    m_cnt[d]++;
                    if (m_cnt[d] == ERR_THRESH && !m_deg[d]) begin
                        m_deg[d] = 1;
                        rise = 1;
                    end
                end
            end
            if (m_mode == 0) begin
                if (ev && nomaj) begin m_mode = 1; m_evals = 1; end
            end else if (m_mode == 1) begin
                if (!(ev && nomaj)) begin
                    m_mode = 0;
                end else begin
                    m_evals++;
                    if (m_evals > MAX_RETRY) begin m_mode = 2; to_fatal = 1; end
                end
            end
            if (m_mode == 2) m_fatal = 1;
            m_irq = rise || to_fatal;
        end
        #1;
        chk("fsm_state", 32'(fsm_state), 32'(m_mode));
        chk("retry_active", 32'(retry_active), 32'(m_mode == 1));
        chk("fatal_error", 32'(fatal_error), 32'(m_fatal));
        chk("err_cnt1", 32'(err_cnt1), 32'(m_cnt[0]));
        chk("err_cnt2", 32'(err_cnt2), 32'(m_cnt[1]));
        chk("err_cnt3", 32'(err_cnt3), 32'(m_cnt[2]));
        chk("degraded", 32'(degraded), 32'({m_deg[2], m_deg[1], m_deg[0]}));
        chk("fault_irq", 32'(fault_irq), 32'(m_irq));
        if (fault_irq) irq_seen++;
    endtask

    initial begin
        int r;
        int idx;
        bit rst, ev, clr;
        bit [2:0] mt;
        bit [1:0] st;

        reset = 1'b1; ex_valid = 1'b0; alu1_alu2_match = 1'b0; alu1_alu3_match = 1'b0;
        alu2_alu3_match = 1'b0; majority_status = 2'b00; clear_counts = 1'b0;

        step(1, 0, 0, 0, 0, 2'b00, 0);
        step(1, 1, 0, 0, 0, 2'b10, 0);
        chk("rst_state", 32'(fsm_state), 32'd0);
        chk("rst_fatal", 32'(fatal_error), 32'd0);

        // all agree for 100 cycles
        irq_seen = 0;
        repeat (100) step(0, 1, 1, 1, 1, 2'b00, 0);
        chk("agree_irq", 32'(irq_seen), 32'd0);
        chk("agree_cnt3", 32'(err_cnt3), 32'd0);

        // ALU3 dissents 16 times
        irq_seen = 0;
        repeat (16) step(0, 1, 1, 0, 0, 2'b01, 0);
        chk("thr_cnt3", 32'(err_cnt3), 32'd16);
        chk("thr_deg", 32'(degraded), 32'b100);
        chk("thr_irq", 32'(irq_seen), 32'd1);
        chk("thr_cnt1", 32'(err_cnt1), 32'd0);

        // one no-majority cycle, then recovery
        step(0, 1, 0, 0, 0, 2'b10, 0);
        chk("rec_state1", 32'(fsm_state), 32'b01);
        step(0, 1, 1, 1, 1, 2'b00, 0);
        chk("rec_state2", 32'(fsm_state), 32'b00);
        chk("rec_fatal", 32'(fatal_error), 32'd0);

        // persistent no-majority escalates to FATAL
        irq_seen = 0;
        repeat (3) step(0, 1, 0, 0, 0, 2'b10, 0);
        chk("fat_state", 32'(fsm_state), 32'b10);
        chk("fat_flag", 32'(fatal_error), 32'd1);
        repeat (3) step(0, 1, 0, 0, 0, 2'b11, 0);
        repeat (2) step(0, 0, 1, 1, 1, 2'b00, 0);
        chk("fat_irq", 32'(irq_seen), 32'd1);
        step(1, 0, 0, 0, 0, 2'b00, 0);
        chk("fat_reset", 32'(fsm_state), 32'b00);

        // ALU2 counter saturation, then clear against a same-cycle dissent
        repeat (255) step(0, 1, 0, 1, 0, 2'b01, 0);
        chk("sat_cnt2", 32'(err_cnt2), 32'd255);
        step(0, 1, 0, 1, 0, 2'b01, 0);
        chk("sat_hold", 32'(err_cnt2), 32'd255);
        step(0, 1, 0, 1, 0, 2'b01, 1);
        chk("clr_cnt2", 32'(err_cnt2), 32'd0);
        chk("clr_deg", 32'(degraded), 32'b000);

        // reset while retrying
        repeat (3) step(0, 1, 0, 0, 1, 2'b01, 0);
        step(0, 1, 0, 0, 0, 2'b10, 0);
        chk("rr_state", 32'(fsm_state), 32'b01);
        irq_seen = 0;
        step(1, 1, 0, 0, 0, 2'b10, 0);
        chk("rr_state0", 32'(fsm_state), 32'b00);
        chk("rr_cnt1", 32'(err_cnt1), 32'd0);
        chk("rr_irq", 32'(irq_seen), 32'd0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            r   = int'($urandom_range(0, 999));
            rst = (m_mode == 2) ? (r < 250) : (r < 3);
            ev  = (m_mode == 2) ? 1'b0 : ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 999) < 5);
            r   = int'($urandom_range(0, 99));
            if (r < 40) begin
                st = 2'b00;
                mt = 3'($urandom_range(0, 7));
            end else if (r < 95) begin
                st = 2'b01;
                if ($urandom_range(0, 9) < 8) begin
                    idx = int'($urandom_range(0, 2));
                    mt  = 3'(1 << idx);
                end else begin
                    mt = 3'($urandom_range(0, 7));
                end
            end else begin
                st = (r < 98) ? 2'b10 : 2'b11;
                mt = 3'($urandom_range(0, 7));
            end
            step(rst, ev, mt[0], mt[1], mt[2], st, clr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tmr_fault_manager.md
TMR_FAULT_MANAGER -- requirements
Module: tmr_fault_manager

Interface
REQ-001 SHALL have parameter CNT_W, default 8, the width of each per-ALU error counter.
REQ-002 SHALL have parameter ERR_THRESH, default 16, the error count at which an ALU is marked degraded.
REQ-003 SHALL have parameter MAX_RETRY, default 2, the number of recompute cycles allowed before fatal.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ex_valid, input, 1 bit: the execute stage holds a valid ALU operation this cycle.
REQ-007 SHALL have ports alu1_alu2_match, alu1_alu3_match and alu2_alu3_match, each input, 1 bit: pairwise TMR result agreement.
REQ-008 SHALL have port majority_status, input, 2 bits, encoded as follows: 00 = all agree; 01 = two agree; 10 or 11 = no majority.
REQ-009 SHALL have port clear_counts, input, 1 bit: clears the error counters and degraded flags.
REQ-010 SHALL have port stall_E, output, 1 bit: holds the pipeline so the execute stage re-evaluates the same operands.
REQ-011 SHALL have port retry_active, output, 1 bit: high while in the RETRY state.
REQ-012 SHALL have port fatal_error, output, 1 bit: sticky unrecoverable-fault flag.
REQ-013 SHALL have ports err_cnt1, err_cnt2 and err_cnt3, each output, CNT_W bits: per-ALU dissent counts.
REQ-014 SHALL have port degraded, output, 3 bits: bit i-1 set means ALU i is degraded.
REQ-015 SHALL have port fault_irq, output, 1 bit: one-cycle interrupt pulse.
REQ-016 SHALL have port fsm_state, output, 2 bits, encoded as follows: 00 = MONITOR; 01 = RETRY; 10 = FATAL.

Function
REQ-017 SHALL classify a cycle as "single fault" when majority_status=01 and exactly one match bit is 1.
REQ-018 SHALL identify the dissenting ALU of a single fault as follows: only a12 set = ALU3; only a13 set = ALU2; only a23 set = ALU1.
REQ-019 SHALL classify as "no majority" any cycle with majority_status of 10 or 11, or with majority_status=01 and a match-bit count other than one.
REQ-020 SHALL drive stall_E combinationally as (fsm_state==FATAL) OR (ex_valid AND no-majority), in every state.
REQ-021 SHALL, on a single fault with ex_valid=1 in MONITOR or RETRY, increment the dissenter's counter by 1, saturating at 2^CNT_W-1, with no stall.
REQ-022 SHALL set the dissenter's degraded bit in the cycle its counter becomes equal to ERR_THRESH; the bit is sticky until clear_counts or reset.
REQ-023 SHALL pulse fault_irq for exactly one cycle on any 0->1 degraded transition and on entry to FATAL; simultaneous causes produce one pulse.
REQ-024 SHALL, when clear_counts=1, zero all counters and degraded bits next cycle, taking priority over a same-cycle increment; it does not affect the FSM or fatal_error.
REQ-025 SHALL, in MONITOR with ex_valid=1 and no majority, go to RETRY with retry_cnt=1.
REQ-026 SHALL, in MONITOR, remain in MONITOR in all other cases.
REQ-027 SHALL, in RETRY with ex_valid=0 (pipeline flushed), go to MONITOR with no fatal.
REQ-028 SHALL, in RETRY with a result that is not no-majority, go to MONITOR; stall_E=0 in that cycle, so the result is accepted.
REQ-029 SHALL, in RETRY with no majority and retry_cnt<MAX_RETRY, increment retry_cnt and stay in RETRY.
REQ-030 SHALL, in RETRY with no majority and retry_cnt==MAX_RETRY, go to FATAL.
REQ-031 SHALL, in FATAL, set fatal_error=1 and hold stall_E=1 until reset; inputs are ignored except for counter and clear updates.
REQ-032 SHALL evaluate at most 1+MAX_RETRY times per faulting operation before FATAL.
REQ-033 SHALL keep retry_active equal to (fsm_state==RETRY).
REQ-034 SHALL update no counters while ex_valid=0.

Reset
REQ-035 SHALL, while reset=1 at a clock edge, set fsm_state=MONITOR, retry_cnt=0, all counters=0, degraded=000, fatal_error=0, fault_irq=0 and retry_active=0.
REQ-036 SHALL, during reset, drive stall_E per REQ-020 with state MONITOR.
REQ-037 SHALL, on reset asserted mid-RETRY or in FATAL, return to MONITOR on the next edge with no fault_irq pulse.

Verification
REQ-038 SHALL cover: ex_valid=1, status 00 for 100 cycles -> stall_E=0 throughout; counters 0; fault_irq never asserted.
REQ-039 SHALL cover: status 01 with only a12 set for 16 valid cycles -> err_cnt3=16; degraded=100 in cycle 16; one fault_irq pulse; err_cnt1=err_cnt2=0.
REQ-040 SHALL cover: MONITOR, status 10 for one cycle, then status 00 -> stall_E=1 in cycle 0 and 0 in cycle 1; fsm_state 01 then 00; fatal_error=0.
REQ-041 SHALL cover: status 10 held, ex_valid=1, MAX_RETRY=2 -> stall_E=1 in cycles 0-2; FATAL at cycle 3; fatal_error=1; fault_irq pulses once; stall_E stays 1 until reset.
REQ-042 SHALL cover: err_cnt2=255 (CNT_W=8) plus another ALU2 dissent -> stays 255; clear_counts in the same cycle as a dissent -> counter reads 0 next cycle.
REQ-043 SHALL cover: reset asserted in RETRY with retry_cnt=1 -> next cycle fsm_state=00, stall_E=ex_valid AND no-majority, all counters 0.
